vscale_dbg_hart_ctrl: RTL and testbench



---
 rtl/vscale_dbg_hart_ctrl_pkg.sv | 25 ++
 rtl/vscale_dbg_hart_ctrl_if.sv | 46 ++++
 rtl/vscale_dbg_hart_ctrl_hart_fsm.sv | 82 ++++++++
 rtl/vscale_dbg_hart_ctrl.sv | 179 +++++++++++++++++
 tb/tb_vscale_dbg_hart_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vscale_dbg_hart_ctrl_pkg.sv
// Shared constants and state encodings for the debug hart controller.
// The register index width and FSM encodings live here so every file agrees on them.
package vscale_dbg_hart_ctrl_pkg;

  localparam int REG_INDEX_W = 13;

  typedef enum logic [1:0] {
    HART_RUNNING  = 2'd0,
    HART_HALTING  = 2'd1,
    HART_HALTED   = 2'd2,
    HART_RESUMING = 2'd3
  } hart_state_e;

  typedef enum logic [1:0] {
    REG_IDLE   = 2'd0,
    REG_ACCESS = 2'd1,
    REG_RESP   = 2'd2
  } reg_state_e;

  // Hart-select width: a single hart still gets a 1-bit selector.
  function automatic int hsel_width(input int n_harts);
    return (n_harts <= 1) ? 1 : $clog2(n_harts);
  endfunction

endpackage

// File: rtl/vscale_dbg_hart_ctrl_if.sv
// Debug-module side of the hart controller: halt/resume requests and the
// register access request/response channels.
interface vscale_dbg_hart_ctrl_if #(
  parameter int N_HARTS = 2,
  parameter int XPR_LEN = 32
);
  localparam int HSEL_W = vscale_dbg_hart_ctrl_pkg::hsel_width(N_HARTS);
  localparam int IDX_W  = vscale_dbg_hart_ctrl_pkg::REG_INDEX_W;

  logic [HSEL_W-1:0]  dm_hartsel;
  logic               dm_haltreq;
  logic               dm_resumereq;
  logic               dm_haltack;
  logic               dm_resumeack;
  logic [N_HARTS-1:0] dm_halted;

  // Handshakes: a request (or response) transfers on a rising edge where valid
  // and ready are both high; the sender holds valid and payload stable until
  // that edge, and ready never depends combinationally on valid.
  logic               dm_reg_req_valid;
  logic               dm_reg_req_ready;
  logic               dm_reg_req_write;
  logic [IDX_W-1:0]   dm_reg_index;
  logic [XPR_LEN-1:0] dm_reg_wdata;
  logic               dm_reg_resp_valid;
  logic               dm_reg_resp_ready;
  logic               dm_reg_resp_err;
  logic [XPR_LEN-1:0] dm_reg_resp_rdata;

  modport master (
    output dm_hartsel, dm_haltreq, dm_resumereq,
    output dm_reg_req_valid, dm_reg_req_write, dm_reg_index, dm_reg_wdata,
    output dm_reg_resp_ready,
    input  dm_haltack, dm_resumeack, dm_halted,
    input  dm_reg_req_ready, dm_reg_resp_valid, dm_reg_resp_err, dm_reg_resp_rdata
  );

  modport slave (
    input  dm_hartsel, dm_haltreq, dm_resumereq,
    input  dm_reg_req_valid, dm_reg_req_write, dm_reg_index, dm_reg_wdata,
    input  dm_reg_resp_ready,
    output dm_haltack, dm_resumeack, dm_halted,
    output dm_reg_req_ready, dm_reg_resp_valid, dm_reg_resp_err, dm_reg_resp_rdata
  );

endinterface

// File: rtl/vscale_dbg_hart_ctrl_hart_fsm.sv
// Per-hart run-control FSM: sequences halt/resume handshakes with one core and
// produces one-cycle acknowledge pulses towards the debug module.
module vscale_dbg_hart_fsm
  import vscale_dbg_hart_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sel,
  input  logic        haltreq,
  input  logic        resumereq,
  input  logic        reg_busy,
  input  logic        core_haltack,
  input  logic        core_resumeack,
  output logic        halted,
  output logic        core_haltreq,
  output logic        core_resumereq,
  output logic        haltack,
  output logic        resumeack,
  output hart_state_e state
);

  hart_state_e state_q, state_d;
  logic        haltack_q, haltack_d;
  logic        resumeack_q, resumeack_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HART_RUNNING;
      haltack_q   <= 1'b0;
      resumeack_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      haltack_q   <= haltack_d;
      resumeack_q <= resumeack_d;
    end
  end

  // A request level is still high during its own ack cycle, so a redundant
  // ack is suppressed while the previous pulse is on the wire.
  always_comb begin
    state_d     = state_q;
    haltack_d   = 1'b0;
    resumeack_d = 1'b0;
    case (state_q)
      HART_RUNNING: begin
        if (sel && haltreq) begin
          state_d = HART_HALTING;
        end else if (sel && resumereq && !resumeack_q) begin
          resumeack_d = 1'b1;
        end
      end
      HART_HALTING: begin
        if (core_haltack) begin
          state_d   = HART_HALTED;
          haltack_d = 1'b1;
        end
      end
      HART_HALTED: begin
        if (sel && resumereq) begin
          if (!reg_busy) state_d = HART_RESUMING;
        end else if (sel && haltreq && !haltack_q) begin
          haltack_d = 1'b1;
        end
      end
      HART_RESUMING: begin
        if (core_resumeack) begin
          state_d     = HART_RUNNING;
          resumeack_d = 1'b1;
        end
      end
      default: state_d = HART_RUNNING;
    endcase
  end

  assign halted         = (state_q == HART_HALTED);
  assign core_haltreq   = (state_q == HART_HALTING);
  assign core_resumereq = (state_q == HART_RESUMING);
  assign haltack        = haltack_q;
  assign resumeack      = resumeack_q;
  assign state          = state_q;

endmodule

// File: rtl/vscale_dbg_hart_ctrl.sv
// Debug hart controller: N per-hart run-control FSMs plus one shared register
// access engine that forwards debug reads/writes to a halted hart.
module vscale_dbg_hart_ctrl
  import vscale_dbg_hart_ctrl_pkg::*;
#(
  parameter int N_HARTS        = 2,
  parameter int XPR_LEN        = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       reset_n,
  vscale_dbg_hart_ctrl_if.slave      dm,
  output logic [N_HARTS-1:0]         core_haltreq,
  output logic [N_HARTS-1:0]         core_resumereq,
  input  logic [N_HARTS-1:0]         core_haltack,
  input  logic [N_HARTS-1:0]         core_resumeack,
  output logic [N_HARTS-1:0]         core_debug_read,
  output logic [N_HARTS-1:0]         core_debug_write,
  output logic [REG_INDEX_W-1:0]     core_register_index,
  output logic [XPR_LEN-1:0]         core_debug_wdata,
  input  logic [N_HARTS*XPR_LEN-1:0] core_debug_rdata,
  input  logic [N_HARTS-1:0]         core_reg_rack,
  input  logic [N_HARTS-1:0]         core_reg_wack,
  output logic [2*N_HARTS-1:0]       dbg_hart_state,
  output reg_state_e                 dbg_reg_state
);

  localparam int          HSEL_W    = hsel_width(N_HARTS);
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [N_HARTS-1:0] hart_halted;
  logic [N_HARTS-1:0] hart_haltack;
  logic [N_HARTS-1:0] hart_resumeack;
  logic [N_HARTS-1:0] hart_reg_busy;
  logic [N_HARTS-1:0] cap_onehot;
  hart_state_e        hart_state [N_HARTS];

  reg_state_e         reg_state_q, reg_state_d;
  logic [HSEL_W-1:0]  cap_sel_q, cap_sel_d;
  logic               cap_write_q, cap_write_d;
  logic [REG_INDEX_W-1:0] cap_index_q, cap_index_d;
  logic [XPR_LEN-1:0] cap_wdata_q, cap_wdata_d;
  logic [15:0]        tmo_cnt_q, tmo_cnt_d;
  logic               resp_err_q, resp_err_d;
  logic [XPR_LEN-1:0] resp_rdata_q, resp_rdata_d;

  logic               sel_rack, sel_wack, cap_ack;
  logic [XPR_LEN-1:0] sel_rdata;
  logic               req_hart_halted;

  // An out-of-range hartsel matches no instance, so it is silently ignored.
  for (genvar i = 0; i < N_HARTS; i++) begin : g_hart
    vscale_dbg_hart_fsm u_hart_fsm (
      .clk            (clk),
      .reset_n        (reset_n),
      .sel            (dm.dm_hartsel == HSEL_W'(i)),
      .haltreq        (dm.dm_haltreq),
      .resumereq      (dm.dm_resumereq),
      .reg_busy       (hart_reg_busy[i]),
      .core_haltack   (core_haltack[i]),
      .core_resumeack (core_resumeack[i]),
      .halted         (hart_halted[i]),
      .core_haltreq   (core_haltreq[i]),
      .core_resumereq (core_resumereq[i]),
      .haltack        (hart_haltack[i]),
      .resumeack      (hart_resumeack[i]),
      .state          (hart_state[i])
    );
    assign dbg_hart_state[2*i +: 2] = hart_state[i];
    assign hart_reg_busy[i]         = (reg_state_q != REG_IDLE) && cap_onehot[i];
  end

  assign dm.dm_haltack   = |hart_haltack;
  assign dm.dm_resumeack = |hart_resumeack;
  assign dm.dm_halted    = hart_halted;

  // Per-hart views of the captured target and of the live request target.
  always_comb begin
    cap_onehot      = '0;
    sel_rack        = 1'b0;
    sel_wack        = 1'b0;
    sel_rdata       = '0;
    req_hart_halted = 1'b0;
    for (int i = 0; i < N_HARTS; i++) begin
      if (cap_sel_q == HSEL_W'(i)) begin
        cap_onehot[i] = 1'b1;
        sel_rack      = core_reg_rack[i];
        sel_wack      = core_reg_wack[i];
        sel_rdata     = core_debug_rdata[i*XPR_LEN +: XPR_LEN];
      end
      if (dm.dm_hartsel == HSEL_W'(i)) req_hart_halted = hart_halted[i];
    end
  end

  assign cap_ack = cap_write_q ? sel_wack : sel_rack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_state_q  <= REG_IDLE;
      cap_sel_q    <= '0;
      cap_write_q  <= 1'b0;
      cap_index_q  <= '0;
      cap_wdata_q  <= '0;
      tmo_cnt_q    <= '0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      reg_state_q  <= reg_state_d;
      cap_sel_q    <= cap_sel_d;
      cap_write_q  <= cap_write_d;
      cap_index_q  <= cap_index_d;
      cap_wdata_q  <= cap_wdata_d;
      tmo_cnt_q    <= tmo_cnt_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  always_comb begin
    reg_state_d  = reg_state_q;
    cap_sel_d    = cap_sel_q;
    cap_write_d  = cap_write_q;
    cap_index_d  = cap_index_q;
    cap_wdata_d  = cap_wdata_q;
    tmo_cnt_d    = tmo_cnt_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    case (reg_state_q)
      REG_IDLE: begin
        if (dm.dm_reg_req_valid) begin
          cap_sel_d   = dm.dm_hartsel;
          cap_write_d = dm.dm_reg_req_write;
          cap_index_d = dm.dm_reg_index;
          cap_wdata_d = dm.dm_reg_wdata;
          tmo_cnt_d   = '0;
          if (req_hart_halted) begin
            reg_state_d = REG_ACCESS;
          end else begin
            reg_state_d  = REG_RESP;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end
        end
      end
      REG_ACCESS: begin
        // An ack arriving on the timeout cycle still wins.
        if (cap_ack) begin
          reg_state_d  = REG_RESP;
          resp_err_d   = 1'b0;
          resp_rdata_d = cap_write_q ? '0 : sel_rdata;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
          if (tmo_cnt_q + 16'd1 == TMO_LIMIT) begin
            reg_state_d  = REG_RESP;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end
        end
      end
      REG_RESP: begin
        if (dm.dm_reg_resp_ready) reg_state_d = REG_IDLE;
      end
      default: reg_state_d = REG_IDLE;
    endcase
  end

  // Ready is forced low while reset is asserted, even though the FSM sits in IDLE.
  assign dm.dm_reg_req_ready  = reset_n && (reg_state_q == REG_IDLE);
  assign dm.dm_reg_resp_valid = (reg_state_q == REG_RESP);
  assign dm.dm_reg_resp_err   = resp_err_q;
  assign dm.dm_reg_resp_rdata = resp_rdata_q;

  assign core_debug_read     = (reg_state_q == REG_ACCESS && !cap_write_q) ? cap_onehot : '0;
  assign core_debug_write    = (reg_state_q == REG_ACCESS &&  cap_write_q) ? cap_onehot : '0;
  assign core_register_index = cap_index_q;
  assign core_debug_wdata    = cap_wdata_q;
  assign dbg_reg_state       = reg_state_q;

endmodule

// File: tb/tb_vscale_dbg_hart_ctrl.sv
// Directed plus randomized bench for vscale_dbg_hart_ctrl with a 3-hart,
// 8-cycle-timeout configuration and a halted-set reference model.
module tb_vscale_dbg_hart_ctrl;
  import vscale_dbg_hart_ctrl_pkg::*;

  localparam int N      = 3;
  localparam int XPR    = 32;
  localparam int TMO    = 8;
  localparam int HSEL_W = hsel_width(N);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  vscale_dbg_hart_ctrl_if #(.N_HARTS(N), .XPR_LEN(XPR)) dm_if ();

  logic [N-1:0]     core_haltreq, core_resumereq, core_haltack, core_resumeack;
  logic [N-1:0]     core_debug_read, core_debug_write, core_reg_rack, core_reg_wack;
  logic [12:0]      core_register_index;
  logic [XPR-1:0]   core_debug_wdata;
  logic [N*XPR-1:0] core_debug_rdata;
  logic [2*N-1:0]   dbg_hart_state;
  reg_state_e       dbg_reg_state;

  vscale_dbg_hart_ctrl #(.N_HARTS(N), .XPR_LEN(XPR), .TIMEOUT_CYCLES(TMO)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .dm                  (dm_if),
    .core_haltreq        (core_haltreq),
    .core_resumereq      (core_resumereq),
    .core_haltack        (core_haltack),
    .core_resumeack      (core_resumeack),
    .core_debug_read     (core_debug_read),
    .core_debug_write    (core_debug_write),
    .core_register_index (core_register_index),
    .core_debug_wdata    (core_debug_wdata),
    .core_debug_rdata    (core_debug_rdata),
    .core_reg_rack       (core_reg_rack),
    .core_reg_wack       (core_reg_wack),
    .dbg_hart_state      (dbg_hart_state),
    .dbg_reg_state       (dbg_reg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit model_halted [N];

  function automatic logic [N-1:0] model_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = model_halted[i];
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue a halt (halt=1) or resume request to hart h; the core answers after
  // 'delay' cycles of request. Opposite-type core acks are sprayed as noise.
  task automatic hart_op(input bit halt, input int h, input int delay);
    bit in_range, redundant, ack, other;
    int req_cyc, ack_cnt, ack_at, exp_req, exp_cnt, exp_at;
    logic [N-1:0] oh, req_vec;
    in_range  = (h < N);
    redundant = 1'b0;
    oh        = '0;
    if (in_range) begin
      oh[h]     = 1'b1;
      redundant = (model_halted[h] == halt);
    end
    req_cyc = 0; ack_cnt = 0; ack_at = -1; other = 1'b0;
    dm_if.dm_hartsel   = HSEL_W'(h);
    dm_if.dm_haltreq   = halt;
    dm_if.dm_resumereq = !halt;
    for (int c = 0; c < delay + 6; c++) begin
      @(posedge clk); #1;
      ack = halt ? dm_if.dm_haltack : dm_if.dm_resumeack;
      if (ack) begin
        ack_cnt++;
        if (ack_at < 0) ack_at = c;
        dm_if.dm_haltreq   = 1'b0;
        dm_if.dm_resumereq = 1'b0;
      end
      req_vec = halt ? core_haltreq : core_resumereq;
      if (req_vec != '0) begin
        req_cyc++;
        if (req_vec != oh) other = 1'b1;
      end
      core_haltack   = halt ? '0 : N'($urandom);
      core_resumeack = halt ? N'($urandom) : '0;
      if (req_vec != '0 && req_cyc == delay) begin
        if (halt) core_haltack = req_vec;
        else      core_resumeack = req_vec;
      end
    end
    dm_if.dm_haltreq = 1'b0; dm_if.dm_resumereq = 1'b0;
    core_haltack = '0; core_resumeack = '0;
    if (!in_range)     begin exp_req = 0;     exp_cnt = 0; exp_at = -1;    end
    else if (redundant) begin exp_req = 0;    exp_cnt = 1; exp_at = 0;     end
    else               begin exp_req = delay; exp_cnt = 1; exp_at = delay; end
    check(halt ? "halt_req_cycles" : "resume_req_cycles", req_cyc, exp_req);
    check("run_ctrl_wrong_hart", other, 0);
    check("run_ctrl_ack_count", ack_cnt, exp_cnt);
    check("run_ctrl_ack_cycle", ack_at, exp_at);
    if (in_range) model_halted[h] = halt;
    check("dm_halted", dm_if.dm_halted, model_vec());
  endtask

  // Register access to hart h; the core acks after 'delay' strobe cycles.
  task automatic reg_op(input int h, input bit wr, input logic [12:0] idx,
                        input logic [XPR-1:0] wd, input int delay, input logic [XPR-1:0] rd);
    bit ok, exp_err, bad, unstable;
    int exp_strb, strobes, c, hold;
    logic [N-1:0] oh, strb, wrong, hit;
    logic [XPR-1:0] exp_rd;
    ok       = (h < N) && model_halted[h];
    exp_strb = !ok ? 0 : ((delay <= TMO) ? delay : TMO);
    exp_err  = !ok || (delay > TMO);
    exp_rd   = (exp_err || wr) ? '0 : rd;
    oh = '0;
    if (h < N) oh[h] = 1'b1;
    check("req_ready_idle", dm_if.dm_reg_req_ready, 1);
    dm_if.dm_hartsel       = HSEL_W'(h);
    dm_if.dm_reg_req_valid = 1'b1;
    dm_if.dm_reg_req_write = wr;
    dm_if.dm_reg_index     = idx;
    dm_if.dm_reg_wdata     = wd;
    @(posedge clk); #1;
    dm_if.dm_reg_req_valid = 1'b0;
    dm_if.dm_reg_index     = ~idx;
    dm_if.dm_reg_wdata     = ~wd;
    strobes = 0; bad = 1'b0; c = 0;
    while (!dm_if.dm_reg_resp_valid && c < TMO + 6) begin
      strb  = wr ? core_debug_write : core_debug_read;
      wrong = wr ? core_debug_read : core_debug_write;
      if (wrong != '0) bad = 1'b1;
      if (strb != '0) begin
        strobes++;
        if (strb != oh || core_register_index != idx || core_debug_wdata != wd) bad = 1'b1;
      end
      hit = (strb != '0 && strobes == delay) ? oh : '0;
      core_reg_rack    = wr ? N'($urandom) : ((N'($urandom) & ~oh) | hit);
      core_reg_wack    = wr ? ((N'($urandom) & ~oh) | hit) : N'($urandom) & ~oh;
      core_debug_rdata = {$urandom, $urandom, $urandom};
      if (h < N) core_debug_rdata[h*XPR +: XPR] = rd;
      @(posedge clk); #1;
      c++;
    end
    core_reg_rack = '0; core_reg_wack = '0;
    check("resp_cycle", c, exp_strb);
    check("strobe_cycles", strobes, exp_strb);
    check("strobe_shape", bad, 0);
    check("resp_err", dm_if.dm_reg_resp_err, exp_err);
    check("resp_rdata", dm_if.dm_reg_resp_rdata, exp_rd);
    hold = $urandom_range(0, 2);
    unstable = 1'b0;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      if (!dm_if.dm_reg_resp_valid || dm_if.dm_reg_resp_err !== exp_err ||
          dm_if.dm_reg_resp_rdata !== exp_rd || core_debug_read != '0 || core_debug_write != '0)
        unstable = 1'b1;
    end
    check("resp_hold_stable", unstable, 0);
    dm_if.dm_reg_resp_ready = 1'b1;
    @(posedge clk); #1;
    dm_if.dm_reg_resp_ready = 1'b0;
    check("resp_valid_after_take", dm_if.dm_reg_resp_valid, 0);
    check("req_ready_after_take", dm_if.dm_reg_req_ready, 1);
  endtask

  initial begin
    bit stray;
    dm_if.dm_hartsel = '0; dm_if.dm_haltreq = 1'b0; dm_if.dm_resumereq = 1'b0;
    dm_if.dm_reg_req_valid = 1'b0; dm_if.dm_reg_req_write = 1'b0;
    dm_if.dm_reg_index = '0; dm_if.dm_reg_wdata = '0; dm_if.dm_reg_resp_ready = 1'b0;
    core_haltack = '0; core_resumeack = '0; core_reg_rack = '0; core_reg_wack = '0;
    core_debug_rdata = '0;
    for (int i = 0; i < N; i++) model_halted[i] = 1'b0;

    // Reset state
    #1;
    check("rst_req_ready", dm_if.dm_reg_req_ready, 0);
    check("rst_halted", dm_if.dm_halted, 0);
    check("rst_resp_valid", dm_if.dm_reg_resp_valid, 0);
    check("rst_core_strobes", {core_haltreq, core_resumereq, core_debug_read, core_debug_write}, 0);
    check("rst_acks", {dm_if.dm_haltack, dm_if.dm_resumeack}, 0);
    #21 reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_req_ready", dm_if.dm_reg_req_ready, 1);

    // Halt hart 1 with a 3-cycle core ack, then read and time out on it
    hart_op(1'b1, 1, 3);
    reg_op(1, 1'b0, 13'h1001, '0, 2, 32'hDEADBEEF);
    reg_op(0, 1'b1, 13'h0123, 32'h1234_5678, 1, '0);
    reg_op(1, 1'b0, 13'h0456, '0, TMO + 4, 32'hCAFE_F00D);
    reg_op(1, 1'b0, 13'h0457, '0, TMO, 32'h0BAD_CAFE);
    reg_op(1, 1'b1, 13'h0789, 32'hA5A5_5A5A, 3, 32'hFFFF_FFFF);

    // Out-of-range hart, then redundant requests
    hart_op(1'b1, 3, 2);
    reg_op(3, 1'b0, 13'h0001, '0, 1, 32'h1111_1111);
    hart_op(1'b1, 1, 2);
    hart_op(1'b0, 0, 2);
    hart_op(1'b0, 1, 2);

    // Randomized mix of run-control and register traffic
    for (int k = 0; k < 40; k++) begin
      int h;
      h = $urandom_range(0, N);
      if ($urandom_range(0, 1) == 1)
        hart_op(1'($urandom_range(0, 1)), h, $urandom_range(1, 4));
      else
        reg_op(h, 1'($urandom_range(0, 1)), 13'($urandom), $urandom,
               $urandom_range(1, TMO + 3), $urandom);
    end

    // Reset while hart 0 is halting and hart 1 has a read outstanding
    if (!model_halted[1]) hart_op(1'b1, 1, 2);
    if (model_halted[0])  hart_op(1'b0, 0, 2);
    dm_if.dm_hartsel = HSEL_W'(0);
    dm_if.dm_haltreq = 1'b1;
    @(posedge clk); #1;
    dm_if.dm_haltreq = 1'b0;
    check("mid_core_haltreq", core_haltreq, 3'b001);
    dm_if.dm_hartsel       = HSEL_W'(1);
    dm_if.dm_reg_req_valid = 1'b1;
    dm_if.dm_reg_req_write = 1'b0;
    dm_if.dm_reg_index     = 13'h0042;
    @(posedge clk); #1;
    dm_if.dm_reg_req_valid = 1'b0;
    check("mid_core_read", core_debug_read, 3'b010);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_haltreq", core_haltreq, 0);
    check("async_rst_read", core_debug_read, 0);
    check("async_rst_ready", dm_if.dm_reg_req_ready, 0);
    check("async_rst_halted", dm_if.dm_halted, 0);
    for (int i = 0; i < N; i++) model_halted[i] = 1'b0;
    @(posedge clk); #3 reset_n = 1'b1;
    stray = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (dm_if.dm_haltack || dm_if.dm_resumeack || dm_if.dm_reg_resp_valid ||
          core_debug_read != '0 || core_haltreq != '0)
        stray = 1'b1;
    end
    check("no_stray_after_rst", stray, 0);
    check("post_rst2_halted", dm_if.dm_halted, model_vec());
    check("post_rst2_ready", dm_if.dm_reg_req_ready, 1);

    // Recovery: access to running hart fails, then succeeds once halted
    reg_op(1, 1'b0, 13'h0010, '0, 1, 32'h7777_7777);
    hart_op(1'b1, 1, 1);
    reg_op(1, 1'b0, 13'h0011, '0, 1, 32'h8888_8888);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
